// File: rtl/timer_bus_arbiter.sv
// timer_bus_arbiter: round-robin arbiter serialising requester register accesses onto the timer peripheral bus.
module timer_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                      i_sysclk,
  input  logic                      i_sysrst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_req_ack,
  output logic                      o_req_err,
  output logic [DATA_W-1:0]         o_req_rdata,
  output logic [2:0]                o_gnt_id,
  output logic                      o_busy,
  output logic                      o_bus_select,
  output logic                      o_bus_wr,
  output logic [ADDR_W-1:0]         o_reg_addr,
  output logic [DATA_W-1:0]         o_bus_data,
  input  logic [DATA_W-1:0]         i_bus_data,
  input  logic                      i_bus_ack
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [2:0] last_gnt, pick;
  logic [7:0] cnt, req_x;
  logic [3:0] idx;
  logic found, sel_wr, bus_ok, bus_end;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  assign req_x = 8'(i_req);
  // first stale-ack cycle (cnt==0) can never complete a transfer
  assign bus_ok = (cnt != 8'd0) && i_bus_ack;
  assign bus_end = bus_ok || (cnt == 8'(TIMEOUT - 1));
  always_comb begin
    pick = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, last_gnt} + 4'(i + 1);
      idx = (idx >= 4'(NUM_REQ)) ? idx - 4'(NUM_REQ) : idx;
      if (!found && req_x[idx[2:0]]) begin
        found = 1'b1;
        pick = idx[2:0];
      end
    end
  end
  always_comb begin
    sel_wr = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (3'(k) == pick) begin
        sel_wr = i_req_wr[k];
        sel_addr = i_req_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = i_req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      state <= IDLE;
      last_gnt <= 3'(NUM_REQ - 1);
      cnt <= '0;
      o_req_ack <= '0;
      o_req_err <= 1'b0;
      o_req_rdata <= '0;
      o_gnt_id <= '0;
      o_busy <= 1'b0;
      o_bus_select <= 1'b0;
      o_bus_wr <= 1'b0;
      o_reg_addr <= '0;
      o_bus_data <= '0;
    end else begin
      o_req_ack <= '0;
      case (state)
        IDLE: if (found) begin
          state <= BUSY;
          o_busy <= 1'b1;
          o_gnt_id <= pick;
          last_gnt <= pick;
          o_bus_select <= 1'b1;
          o_bus_wr <= sel_wr;
          o_reg_addr <= sel_addr;
          o_bus_data <= sel_wdata;
          cnt <= '0;
        end
        BUSY: if (bus_end) begin
          state <= DONE;
          o_bus_select <= 1'b0;
          o_bus_wr <= 1'b0;
          o_reg_addr <= '0;
          o_bus_data <= '0;
          o_req_ack <= {{(NUM_REQ-1){1'b0}}, 1'b1} << o_gnt_id;
          o_req_err <= !bus_ok;
          o_req_rdata <= (bus_ok && !o_bus_wr) ? i_bus_data : '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
        default: begin
          state <= IDLE;
          o_busy <= 1'b0;
          o_req_err <= 1'b0;
          o_req_rdata <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_timer_bus_arbiter.sv
// tb_timer_bus_arbiter: vector table, reset/contention sequences and randomized traffic against a transaction-level model.
module tb_timer_bus_arbiter;
  localparam int N = 3;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int TO = 15;
  typedef struct {
    int id;
    bit wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int mode;
    logic [DW-1:0] rdata;
    bit err;
    int lat;
  } vec_t;
  logic i_sysclk, i_sysrst_n;
  logic [N-1:0] req, wr;
  logic [AW-1:0] addr [N];
  logic [DW-1:0] wd [N];
  logic [N*AW-1:0] req_addr_bus;
  logic [N*DW-1:0] req_wd_bus;
  logic [N-1:0] o_req_ack;
  logic o_req_err, o_busy, o_bus_select, o_bus_wr;
  logic [DW-1:0] o_req_rdata, o_bus_data, bus_data;
  logic [2:0] o_gnt_id;
  logic [AW-1:0] o_reg_addr;
  logic bus_ack;
  logic [DW-1:0] mem [16];
  int mode;
  int nchk = 0;
  int nerr = 0;
  vec_t tbl [7];

  timer_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_sysclk(i_sysclk), .i_sysrst_n(i_sysrst_n),
    .i_req(req), .i_req_wr(wr), .i_req_addr(req_addr_bus), .i_req_wdata(req_wd_bus),
    .o_req_ack(o_req_ack), .o_req_err(o_req_err), .o_req_rdata(o_req_rdata),
    .o_gnt_id(o_gnt_id), .o_busy(o_busy), .o_bus_select(o_bus_select), .o_bus_wr(o_bus_wr),
    .o_reg_addr(o_reg_addr), .o_bus_data(o_bus_data), .i_bus_data(bus_data), .i_bus_ack(bus_ack)
  );

  initial i_sysclk = 1'b0;
  always #5 i_sysclk = ~i_sysclk;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_addr_bus[k*AW +: AW] = addr[k];
      req_wd_bus[k*DW +: DW] = wd[k];
    end
  end

  function automatic logic [DW-1:0] init_val(int i);
    return (i == 3) ? 16'h1234 : (16'h0F0F ^ (16'(i) * 16'h1111));
  endfunction

  // peripheral: mode 0 nominal registered ack, 1 never acks, 2 ack stuck high
  always @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      bus_ack <= 1'b0;
      bus_data <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else begin
      bus_ack <= (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : (o_bus_select && !bus_ack);
      if (o_bus_select) begin
        bus_data <= mem[o_reg_addr];
        if (o_bus_wr) mem[o_reg_addr] <= o_bus_data;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    i_sysrst_n = 1'b0;
    req = '0;
    mode = 0;
    repeat (2) @(negedge i_sysclk);
    i_sysrst_n = 1'b1;
  endtask

  task automatic do_txn(vec_t v);
    int lat;
    bit seen;
    mode = v.mode;
    addr[v.id] = v.addr;
    wr[v.id] = v.wr;
    wd[v.id] = v.wdata;
    req = '0;
    req[v.id] = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge i_sysclk);
      lat++;
      if (lat == 1) begin
        chk("txn_select", o_bus_select, 1);
        chk("txn_bus_wr", o_bus_wr, v.wr);
        chk("txn_reg_addr", o_reg_addr, v.addr);
        chk("txn_bus_data", o_bus_data, v.wdata);
      end
      if (o_req_ack != '0) seen = 1'b1;
    end
    chk("txn_latency", lat, v.lat);
    chk("txn_ack", o_req_ack, N'(1) << v.id);
    chk("txn_rdata", o_req_rdata, v.rdata);
    chk("txn_err", o_req_err, v.err);
    chk("txn_gnt_id", o_gnt_id, v.id);
    req = '0;
    @(negedge i_sysclk);
    chk("txn_ack_clear", o_req_ack, 0);
    chk("txn_rdata_clear", o_req_rdata, 0);
    chk("txn_err_clear", o_req_err, 0);
    chk("txn_idle", o_busy, 0);
  endtask

  initial begin
    int t_ack [4];
    logic [N-1:0] v_ack [4];
    logic [DW-1:0] v_rd [4];
    int nack;
    logic [DW-1:0] ref_mem [16];
    int cnt, cur, last, exp_gnt, c;
    bit g, c_wr;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wd, exp_rd;
    tbl[0] = '{0, 1'b0, 4'd3, 16'h0000, 0, 16'h1234, 1'b0, 3};
    tbl[1] = '{1, 1'b1, 4'd4, 16'hA55A, 0, 16'h0000, 1'b0, 3};
    tbl[2] = '{1, 1'b0, 4'd4, 16'h0000, 0, 16'hA55A, 1'b0, 3};
    tbl[3] = '{0, 1'b0, 4'd1, 16'h0000, 1, 16'h0000, 1'b1, TO + 1};
    tbl[4] = '{0, 1'b0, 4'd3, 16'h0000, 0, 16'h1234, 1'b0, 3};
    tbl[5] = '{2, 1'b0, 4'd5, 16'h0000, 2, 16'h5A5A, 1'b0, 3};
    tbl[6] = '{2, 1'b0, 4'd6, 16'h0000, 2, 16'h6969, 1'b0, 3};
    for (int k = 0; k < N; k++) begin
      addr[k] = '0;
      wd[k] = '0;
    end
    wr = '0;
    req = '0;
    mode = 0;
    i_sysrst_n = 1'b0;
    @(negedge i_sysclk);
    chk("rst_ack", o_req_ack, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_select", {o_bus_select, o_bus_wr, o_reg_addr}, 0);
    chk("rst_bus_data", o_bus_data, 0);
    chk("rst_rdata_err", {o_req_err, o_req_rdata}, 0);
    chk("rst_gnt_id", o_gnt_id, 0);
    @(negedge i_sysclk);
    i_sysrst_n = 1'b1;
    for (int i = 0; i < 7; i++) do_txn(tbl[i]);

    do_reset();
    req = '0;
    req[1] = 1'b1;
    wr[1] = 1'b1;
    addr[1] = 4'd7;
    wd[1] = 16'hBEEF;
    repeat (2) @(negedge i_sysclk);
    chk("abort_select", o_bus_select, 1);
    chk("abort_gnt", o_gnt_id, 1);
    #2 i_sysrst_n = 1'b0;
    #1;
    chk("abort_out_a", {o_req_ack, o_req_err, o_gnt_id, o_busy, o_bus_select, o_bus_wr, o_reg_addr}, 0);
    chk("abort_out_b", {o_req_rdata, o_bus_data}, 0);
    req = '0;
    req[0] = 1'b1;
    req[1] = 1'b1;
    wr = '0;
    addr[0] = 4'd2;
    addr[1] = 4'd9;
    wd[1] = '0;
    repeat (2) begin
      @(negedge i_sysclk);
      chk("abort_no_ack", o_req_ack, 0);
    end
    i_sysrst_n = 1'b1;
    nack = 0;
    for (int t = 1; t <= 30; t++) begin
      @(negedge i_sysclk);
      if (o_req_ack != '0 && nack < 4) begin
        t_ack[nack] = t;
        v_ack[nack] = o_req_ack;
        v_rd[nack] = o_req_rdata;
        nack++;
      end
    end
    chk("cont_count", nack, 4);
    for (int j = 0; j < nack; j++) begin
      chk("cont_ack", v_ack[j], (j % 2 == 0) ? 3'b001 : 3'b010);
      chk("cont_rdata", v_rd[j], (j % 2 == 0) ? init_val(2) : init_val(9));
      chk("cont_time", t_ack[j], 3 + 4 * j);
    end
    req = '0;
    repeat (3) @(negedge i_sysclk);

    do_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    last = N - 1;
    exp_gnt = 0;
    cnt = 0;
    cur = 0;
    c_wr = 1'b0;
    c_addr = '0;
    c_wd = '0;
    exp_rd = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge i_sysclk);
      if (cnt > 0) cnt--;
      chk("rnd_ack", o_req_ack, (cnt == 1) ? N'(1) << cur : 0);
      chk("rnd_busy", o_busy, cnt != 0);
      chk("rnd_gnt_id", o_gnt_id, exp_gnt);
      chk("rnd_bus", {o_bus_select, o_bus_wr, o_reg_addr, o_bus_data},
          (cnt == 3 || cnt == 2) ? {1'b1, c_wr, c_addr, c_wd} : 0);
      chk("rnd_rdata", {o_req_err, o_req_rdata}, (cnt == 1) ? {1'b0, exp_rd} : 0);
      if (cnt == 1) req[cur] = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(3) == 0) begin
          req[k] = 1'b1;
          wr[k] = 1'($urandom_range(1));
          addr[k] = 4'($urandom_range(15));
          wd[k] = 16'($urandom);
        end
      end
      if (cnt == 0 && req != '0) begin
        g = 1'b0;
        for (int i = 1; i <= N; i++) begin
          c = (last + i) % N;
          if (!g && req[c]) begin
            g = 1'b1;
            cur = c;
          end
        end
        last = cur;
        exp_gnt = cur;
        cnt = 4;
        c_wr = wr[cur];
        c_addr = addr[cur];
        c_wd = wd[cur];
        exp_rd = c_wr ? 16'h0 : ref_mem[c_addr];
        if (c_wr) ref_mem[c_addr] = c_wd;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
